// File: rtl/ro_sense_pkg.sv
// Shared types and constants for the ring-oscillator sense controller.
package ro_sense_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWarmup,
      StMeasure,
      StDone
   } state_e;

   // Shortest warm-up the ring can be trusted to settle in.
   localparam int unsigned MIN_WARM = 3;

endpackage

// File: rtl/ro_edge_sync.sv
// Brings the free-running RO output into the mclk domain and flags its rising edges.
module ro_edge_sync (
   input  logic mclk,
   input  logic puc_rst,
   input  logic ro_out,
   output logic ro_edge
);

   logic sync1_q, sync2_q, prev_q;

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= ro_out;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign ro_edge = sync2_q & ~prev_q;

endmodule

// File: rtl/ro_sense_ctrl.sv
// Sequences one RO glitch sensor: enable, warm up, count edges over a window, band-check.
module ro_sense_ctrl
   import ro_sense_pkg::*;
#(
   parameter int unsigned CW       = 16,
   parameter int unsigned GW       = 16,
   parameter int unsigned WARM_CYC = 8
) (
   input  logic          mclk,
   input  logic          puc_rst,
   input  logic          start,
   input  logic          stop,
   input  logic          cont,
   input  logic [GW-1:0] gate_len,
   input  logic [CW-1:0] thr_lo,
   input  logic [CW-1:0] thr_hi,
   input  logic          alarm_clr,
   input  logic          ro_out,
   output logic          ro_en,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] count,
   output logic          alarm
);

   // Too short a warm-up lets the ring start counting before it oscillates cleanly.
   localparam int unsigned WarmEff = (WARM_CYC < MIN_WARM) ? MIN_WARM : WARM_CYC;
   localparam int unsigned WW = $clog2(WarmEff);
   localparam logic [WW-1:0] WarmLast = WW'(WarmEff - 1);
   localparam logic [CW-1:0] CntMax = {CW{1'b1}};

   state_e        state_q;
   logic [WW-1:0] warm_cnt_q;
   logic [GW-1:0] gate_cnt_q, gate_last_q;
   logic [CW-1:0] edge_cnt_q, thr_lo_q, thr_hi_q, count_q;
   logic          cont_q, ro_en_q, busy_q, done_q, alarm_q;

   logic          ro_edge;
   logic [CW-1:0] edge_cnt_inc;
   logic [GW-1:0] gate_last;
   logic          win_fail, hold_alarm;

   ro_edge_sync u_edge_sync (
      .mclk    (mclk),
      .puc_rst (puc_rst),
      .ro_out  (ro_out),
      .ro_edge (ro_edge)
   );

   always_comb begin
      edge_cnt_inc = edge_cnt_q;
      if (ro_edge && (edge_cnt_q != CntMax)) begin
         edge_cnt_inc = edge_cnt_q + 1'b1;
      end
      gate_last = (gate_len == '0) ? '0 : gate_len - 1'b1;
      win_fail  = (edge_cnt_inc < thr_lo_q) || (edge_cnt_inc > thr_hi_q);
      // A clear landing on the DONE cycle of a failing window must not hide that failure.
      hold_alarm = (state_q == StDone) && ((count_q < thr_lo_q) || (count_q > thr_hi_q));
   end

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state_q     <= StIdle;
         warm_cnt_q  <= '0;
         gate_cnt_q  <= '0;
         gate_last_q <= '0;
         edge_cnt_q  <= '0;
         thr_lo_q    <= '0;
         thr_hi_q    <= '0;
         cont_q      <= 1'b0;
         ro_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         count_q     <= '0;
         alarm_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (alarm_clr && !hold_alarm) begin
            alarm_q <= 1'b0;
         end
         if (stop) begin
            state_q <= StIdle;
            ro_en_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     state_q     <= StWarmup;
                     ro_en_q     <= 1'b1;
                     busy_q      <= 1'b1;
                     warm_cnt_q  <= '0;
                     cont_q      <= cont;
                     gate_last_q <= gate_last;
                     thr_lo_q    <= thr_lo;
                     thr_hi_q    <= thr_hi;
                  end
               end
               StWarmup: begin
                  if (warm_cnt_q == WarmLast) begin
                     state_q    <= StMeasure;
                     edge_cnt_q <= '0;
                     gate_cnt_q <= '0;
                  end else begin
                     warm_cnt_q <= warm_cnt_q + 1'b1;
                  end
               end
               StMeasure: begin
                  if (gate_cnt_q == gate_last_q) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                     count_q <= edge_cnt_inc;
                     // Placed after the clear so a coincident set wins.
                     if (win_fail) begin
                        alarm_q <= 1'b1;
                     end
                  end else begin
                     gate_cnt_q <= gate_cnt_q + 1'b1;
                     edge_cnt_q <= edge_cnt_inc;
                  end
               end
               StDone: begin
                  if (cont_q) begin
                     state_q    <= StMeasure;
                     edge_cnt_q <= '0;
                     gate_cnt_q <= '0;
                  end else begin
                     state_q <= StIdle;
                     ro_en_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  ro_en_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ro_en = ro_en_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign count = count_q;
   assign alarm = alarm_q;

endmodule

// File: tb/tb_ro_sense_ctrl.sv
// Bench for ro_sense_ctrl: directed table, corner sequences and random windows vs an edge model.
module tb_ro_sense_ctrl;

   localparam int W = 8;
   localparam int HistLen = 16384;

   logic        mclk = 1'b0;
   logic        puc_rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, cont = 1'b0, alarm_clr = 1'b0, ro_out = 1'b0;
   logic [15:0] gate_len = '0, thr_lo = '0, thr_hi = '0;
   logic        ro_en, busy, done, alarm;
   logic [15:0] count;
   logic        ro_en_s, busy_s, done_s, alarm_s;
   logic [3:0]  count_s;

   ro_sense_ctrl #(.CW(16), .GW(16), .WARM_CYC(W)) dut (
      .mclk(mclk), .puc_rst(puc_rst), .start(start), .stop(stop), .cont(cont),
      .gate_len(gate_len), .thr_lo(thr_lo), .thr_hi(thr_hi), .alarm_clr(alarm_clr),
      .ro_out(ro_out), .ro_en(ro_en), .busy(busy), .done(done), .count(count), .alarm(alarm)
   );

   ro_sense_ctrl #(.CW(4), .GW(16), .WARM_CYC(W)) dut_s (
      .mclk(mclk), .puc_rst(puc_rst), .start(start), .stop(stop), .cont(cont),
      .gate_len(gate_len), .thr_lo(thr_lo[3:0]), .thr_hi(thr_hi[3:0]), .alarm_clr(alarm_clr),
      .ro_out(ro_out), .ro_en(ro_en_s), .busy(busy_s), .done(done_s), .count(count_s),
      .alarm(alarm_s)
   );

   always #5 mclk = ~mclk;

   typedef struct {
      int gate;
      int lo;
      int hi;
      int mode;
      int hp;
      bit clr;
      int exp_cnt;
      int exp_cnt_s;
      bit exp_alm;
      int exp_lat;
   } vec_t;

   int  cyc = 0;
   int  last_t0 = 0;
   int  n_vec = 0, n_err = 0;
   bit  alarm_m = 1'b0;
   bit  ro_hist [HistLen];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Value seen by the DUT in cycle n is recorded, then the edge ending cycle n is taken.
   task automatic tick();
      if (cyc < HistLen) ro_hist[cyc] = ro_out;
      @(posedge mclk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      ro_out = 1'b0;
      repeat (n) tick();
   endtask

   // mode 0: square wave with half-period hp starting low; 1: constant high; 2: random bits.
   function automatic bit gen(input int mode, input int hp, input int rel);
      if (mode == 0) return ((rel / hp) % 2) == 1;
      if (mode == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   // Synchronised rising edge visible in cycle c comes from ro_out low in c-3 and high in c-2.
   function automatic int model_edges(input int gate);
      int geff, first, n;
      geff  = (gate == 0) ? 1 : gate;
      first = last_t0 + 1 + W;
      n     = 0;
      for (int c = first; c < first + geff; c++) begin
         if (c >= 3 && c < HistLen && ro_hist[c-2] && !ro_hist[c-3]) n++;
      end
      return n;
   endfunction

   task automatic run(input int gate, input int lo, input int hi, input int mode, input int hp,
                      input bit clr_pre, input bit clr_done, input int inj_rel,
                      input int inj_kind, output int lat, output int cnt, output int cnt_s,
                      output bit alm, output bit en1, output bit en_after, output bit s_ok,
                      output logic [4:0] post);
      int geff, exp_lat, rel;
      geff    = (gate == 0) ? 1 : gate;
      exp_lat = 1 + W + geff;
      lat = -1; cnt = -1; cnt_s = -1; alm = 0; en1 = 0; en_after = 0; s_ok = 0; post = '0;
      if (clr_pre) begin
         alarm_clr = 1'b1;
         tick();
         alarm_clr = 1'b0;
      end
      cont = 1'b0; gate_len = 16'(gate); thr_lo = 16'(lo); thr_hi = 16'(hi);
      start = 1'b1; ro_out = gen(mode, hp, 0); last_t0 = cyc;
      tick();
      // Config is latched at start; scramble it to show later changes are ignored.
      start = 1'b0; cont = 1'($urandom_range(0, 1)); gate_len = 16'($urandom);
      thr_lo = 16'($urandom); thr_hi = 16'($urandom);
      for (int k = 0; k < exp_lat + 10; k++) begin
         rel = cyc - last_t0;
         if (rel == 1) en1 = ro_en && busy;
         if (inj_kind > 0 && rel == inj_rel + 1) post = {ro_en, busy, done, alarm, count == '0};
         if (done && lat < 0) begin
            lat = rel; cnt = int'(count); cnt_s = int'(count_s); alm = alarm;
            s_ok = done_s && busy_s && ro_en_s;
         end else if (lat >= 0 && rel == lat + 1) begin
            en_after = !ro_en && !busy && !done;
            break;
         end
         ro_out    = gen(mode, hp, rel);
         alarm_clr = clr_done && (rel == exp_lat - 1 || rel == exp_lat);
         start     = (inj_kind == 0 && rel == inj_rel);
         stop      = (inj_kind == 1 && rel == inj_rel);
         puc_rst   = (inj_kind == 2 && rel == inj_rel);
         tick();
      end
      start = 1'b0; stop = 1'b0; puc_rst = 1'b0; alarm_clr = 1'b0; cont = 1'b0;
   endtask

   vec_t        tbl [12];
   int          lat, cnt, cnt_s, mc, nd, off, rel, g, lo, hi;
   bit          alm, en1, en_after, s_ok, clr;
   logic [4:0]  post;

   initial begin
      tbl[0]  = '{100,  8,    12, 0, 5, 0, 10, 10, 0, 109};
      tbl[1]  = '{100, 20,    30, 0, 5, 0, 10, 10, 1, 109};
      tbl[2]  = '{100,  8,    12, 0, 5, 0, 10, 10, 1, 109};
      tbl[3]  = '{100,  8,    12, 0, 5, 1, 10, 10, 0, 109};
      tbl[4]  = '{100,  0, 65535, 0, 2, 0, 25, 15, 0, 109};
      tbl[5]  = '{  0,  0,     5, 0, 7, 0,  1,  1, 0,  10};
      tbl[6]  = '{ 10,  0,     5, 0, 3, 0,  2,  2, 0,  19};
      tbl[7]  = '{  9,  1,     1, 0, 5, 0,  1,  1, 0,  18};
      tbl[8]  = '{  8,  1,     1, 0, 5, 0,  0,  0, 1,  17};
      tbl[9]  = '{100,  0,     0, 1, 1, 1,  0,  0, 0, 109};
      tbl[10] = '{ 20,  5,     4, 0, 5, 0,  2,  2, 1,  29};
      tbl[11] = '{ 30,  3,     3, 0, 5, 1,  3,  3, 0,  39};

      puc_rst = 1'b1;
      repeat (4) tick();
      chk("rst_ro_en", int'(ro_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_alarm", int'(alarm), 0);
      puc_rst = 1'b0;
      idle(5);

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].clr) alarm_m = 1'b0;
         run(tbl[i].gate, tbl[i].lo, tbl[i].hi, tbl[i].mode, tbl[i].hp, tbl[i].clr, 1'b0, -1,
             0, lat, cnt, cnt_s, alm, en1, en_after, s_ok, post);
         mc = model_edges(tbl[i].gate);
         if (mc < tbl[i].lo || mc > tbl[i].hi) alarm_m = 1'b1;
         chk($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
         chk($sformatf("v%0d_count", i), cnt, tbl[i].exp_cnt);
         chk($sformatf("v%0d_count_model", i), cnt, mc);
         chk($sformatf("v%0d_count_cw4", i), cnt_s, tbl[i].exp_cnt_s);
         chk($sformatf("v%0d_alarm", i), int'(alm), int'(tbl[i].exp_alm));
         chk($sformatf("v%0d_alarm_model", i), int'(alm), int'(alarm_m));
         chk($sformatf("v%0d_ro_en_t1", i), int'(en1), 1);
         chk($sformatf("v%0d_idle_after", i), int'(en_after), 1);
         chk($sformatf("v%0d_cw4_done", i), int'(s_ok), 1);
         idle(5);
      end

      // Clear coinciding with a failing DONE: set wins.
      run(100, 20, 30, 0, 5, 1'b0, 1'b1, -1, 0, lat, cnt, cnt_s, alm, en1, en_after, s_ok, post);
      chk("setclr_alarm_done", int'(alm), 1);
      chk("setclr_alarm_after", int'(alarm), 1);
      alarm_clr = 1'b1;
      tick();
      alarm_clr = 1'b0;
      chk("clr_alarm", int'(alarm), 0);
      alarm_m = 1'b0;
      idle(5);

      // Start during MEASURE is ignored.
      run(100, 8, 12, 0, 5, 1'b0, 1'b0, 50, 0, lat, cnt, cnt_s, alm, en1, en_after, s_ok, post);
      chk("busy_start_latency", lat, 109);
      chk("busy_start_count", cnt, 10);
      idle(5);

      // Stop during WARMUP: no done, previous count kept.
      run(100, 8, 12, 0, 5, 1'b0, 1'b0, 4, 1, lat, cnt, cnt_s, alm, en1, en_after, s_ok, post);
      chk("stop_warm_ro_en", int'(post[4]), 0);
      chk("stop_warm_busy", int'(post[3]), 0);
      chk("stop_warm_no_done", lat, -1);
      chk("stop_warm_count_kept", int'(count), 10);
      idle(5);

      // Reset mid-MEASURE after a failing window.
      run(100, 20, 30, 0, 5, 1'b0, 1'b0, -1, 0, lat, cnt, cnt_s, alm, en1, en_after, s_ok, post);
      chk("pre_rst_alarm", int'(alarm), 1);
      run(100, 8, 12, 0, 5, 1'b0, 1'b0, 50, 2, lat, cnt, cnt_s, alm, en1, en_after, s_ok, post);
      chk("rst_mid_outputs", int'(post), 1);
      chk("rst_mid_no_done", lat, -1);
      alarm_m = 1'b0;
      idle(5);

      // Simultaneous start and stop stays idle.
      gate_len = 16'd10; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("start_stop_busy", int'(busy), 0);
      chk("start_stop_ro_en", int'(ro_en), 0);
      idle(5);

      // Continuous mode: done every 51 cycles, ro_en never drops, stop ends it.
      cont = 1'b1; gate_len = 16'd50; thr_lo = 16'd0; thr_hi = 16'd100;
      start = 1'b1; ro_out = gen(0, 5, 0); last_t0 = cyc;
      tick();
      start = 1'b0; cont = 1'b0;
      nd = 0; off = 0;
      for (int k = 0; k < 240; k++) begin
         rel = cyc - last_t0;
         if (rel <= 170 && !ro_en) off++;
         if (done) begin
            if (nd < 3) begin
               chk($sformatf("cont_done%0d_time", nd), rel, 59 + 51 * nd);
               chk($sformatf("cont_done%0d_count", nd), int'(count), 5);
            end
            nd++;
         end
         if (rel == 171) begin
            chk("cont_stop_busy", int'(busy), 0);
            chk("cont_stop_ro_en", int'(ro_en), 0);
         end
         ro_out = gen(0, 5, rel);
         stop   = (rel == 170);
         tick();
      end
      stop = 1'b0;
      chk("cont_done_total", nd, 3);
      chk("cont_ro_en_low_cycles", off, 0);
      idle(5);

      // Random windows against the edge model.
      for (int i = 0; i < 15; i++) begin
         g   = int'($urandom_range(0, 60));
         lo  = int'($urandom_range(0, 20));
         hi  = int'($urandom_range(0, 25));
         clr = 1'($urandom_range(0, 1));
         if (clr) alarm_m = 1'b0;
         run(g, lo, hi, 2, 1, clr, 1'b0, -1, 0, lat, cnt, cnt_s, alm, en1, en_after, s_ok, post);
         mc = model_edges(g);
         if (mc < lo || mc > hi) alarm_m = 1'b1;
         chk($sformatf("r%0d_latency", i), lat, 1 + W + ((g == 0) ? 1 : g));
         chk($sformatf("r%0d_count", i), cnt, mc);
         chk($sformatf("r%0d_count_cw4", i), cnt_s, (mc > 15) ? 15 : mc);
         chk($sformatf("r%0d_alarm", i), int'(alm), int'(alarm_m));
         idle(5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
